// File: rtl/kanagawa_fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter and its round-robin picker.
package kanagawa_fifo_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  // Index width for n requesters; never zero so single-entry ports stay legal.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kanagawa_rr_picker.sv
// Combinational round-robin picker: first set bit of the request mask at or after ptr_i,
// wrapping modulo N.
module kanagawa_rr_picker
  import kanagawa_fifo_arb_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req_mask_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            found_o,
  output logic [IdxW-1:0] idx_o
);

  int unsigned cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= N) cand = cand - N;
      if (!found_o && req_mask_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/kanagawa_fifo_write_arbiter.sv
// Round-robin arbiter sharing one registered FIFO write port among N requesters, with an
// optional packet-atomic mode that holds the grant until the owner's last beat.
module kanagawa_fifo_write_arbiter
  import kanagawa_fifo_arb_pkg::*;
#(
  parameter int unsigned N           = 2,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PACKET_MODE = 0,
  parameter int unsigned MAX_PACKET  = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid_in,
  input  logic [N*WIDTH-1:0]   req_data_in,
  input  logic [N-1:0]         req_last_in,
  output logic [N-1:0]         req_ready_out,
  output logic                 wrreq_out,
  output logic [WIDTH-1:0]     data_out,
  input  logic                 full_in,
  input  logic                 almost_full_in,
  output logic [$clog2(N)-1:0] grant_idx_out,
  output logic                 locked_out,
  output logic                 overflow_err_out,
  output logic                 watchdog_err_out
);

  localparam int unsigned IdxW = idx_width(N);
  localparam int unsigned CntW = $clog2(MAX_PACKET + 1);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("kanagawa_fifo_write_arbiter: N must be in 2..16");
  end
  if (MAX_PACKET < 2) begin : g_bad_max_packet
    $error("kanagawa_fifo_write_arbiter: MAX_PACKET must be at least 2");
  end

  function automatic logic [IdxW-1:0] next_idx(logic [IdxW-1:0] idx);
    return (idx == IdxW'(N - 1)) ? '0 : idx + 1'b1;
  endfunction

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  grant_q, grant_d;
  logic             wd_err_q, wd_err_d;
  logic             ovf_err_q;
  logic             wrreq_q;
  logic [WIDTH-1:0] data_q;

  logic             sel_found;
  logic [IdxW-1:0]  sel_idx;
  logic [IdxW-1:0]  acc_idx;
  logic             acc_vin;
  logic             acc_last;
  logic [WIDTH-1:0] acc_data;
  logic             can_issue;
  logic             accept;

  kanagawa_rr_picker #(
    .N    (N),
    .IdxW (IdxW)
  ) u_picker (
    .req_mask_i (req_valid_in),
    .ptr_i      (ptr_q),
    .found_o    (sel_found),
    .idx_o      (sel_idx)
  );

  // almost_full leaves room for the output register plus one cycle of status lag.
  assign can_issue = !full_in && !almost_full_in;

  always_comb begin
    acc_idx  = (state_q == StLocked) ? owner_q : sel_idx;
    acc_vin  = 1'b0;
    acc_last = 1'b0;
    acc_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (acc_idx == IdxW'(i)) begin
        acc_vin  = req_valid_in[i];
        acc_last = req_last_in[i];
        acc_data = req_data_in[i*WIDTH +: WIDTH];
      end
    end
    // In IDLE a valid at sel_idx implies sel_found; in LOCKED only the owner may go.
    accept = can_issue && !rst && acc_vin && ((state_q == StLocked) || sel_found);
    for (int unsigned i = 0; i < N; i++) begin
      req_ready_out[i] = accept && (acc_idx == IdxW'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    wd_err_d = wd_err_q;
    if (accept) begin
      grant_d = acc_idx;
      unique case (state_q)
        StIdle: begin
          if (PACKET_MODE == 0 || acc_last) begin
            ptr_d = next_idx(acc_idx);
          end else begin
            state_d = StLocked;
            owner_d = acc_idx;
            cnt_d   = CntW'(1);
          end
        end
        StLocked: begin
          if (acc_last) begin
            state_d = StIdle;
            ptr_d   = next_idx(owner_q);
            cnt_d   = '0;
          end else if (cnt_q + CntW'(1) == CntW'(MAX_PACKET)) begin
            // Runaway packet: release the port so other requesters are not starved.
            state_d  = StIdle;
            ptr_d    = next_idx(owner_q);
            cnt_d    = '0;
            wd_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      wd_err_q  <= 1'b0;
      ovf_err_q <= 1'b0;
      wrreq_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      wd_err_q  <= wd_err_d;
      ovf_err_q <= ovf_err_q | (wrreq_q & full_in);
      wrreq_q   <= accept;
      if (accept) data_q <= acc_data;
    end
  end

  assign wrreq_out        = wrreq_q;
  assign data_out         = data_q;
  assign grant_idx_out    = grant_q;
  assign locked_out       = (state_q == StLocked);
  assign overflow_err_out = ovf_err_q;
  assign watchdog_err_out = wd_err_q;

endmodule

// File: tb/tb_kanagawa_fifo_write_arbiter.sv
// Directed bench: DUT a is N=3 per-beat round-robin, DUT b is N=3 packet mode with MAX_PACKET=4.
module tb_kanagawa_fifo_write_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  a_valid, a_last, a_ready, b_valid, b_last, b_ready;
  logic [23:0] a_data, b_data;
  logic        a_wr, a_full, a_af, a_lock, a_ovf, a_wd;
  logic        b_wr, b_full, b_af, b_lock, b_ovf, b_wd;
  logic [7:0]  a_dout, b_dout;
  logic [1:0]  a_gidx, b_gidx;

  int n_cmp = 0;
  int n_bad = 0;

  kanagawa_fifo_write_arbiter #(
    .N(3), .WIDTH(8), .PACKET_MODE(0), .MAX_PACKET(256)
  ) u_dut_a (
    .clk              (clk),
    .rst              (rst),
    .req_valid_in     (a_valid),
    .req_data_in      (a_data),
    .req_last_in      (a_last),
    .req_ready_out    (a_ready),
    .wrreq_out        (a_wr),
    .data_out         (a_dout),
    .full_in          (a_full),
    .almost_full_in   (a_af),
    .grant_idx_out    (a_gidx),
    .locked_out       (a_lock),
    .overflow_err_out (a_ovf),
    .watchdog_err_out (a_wd)
  );

  kanagawa_fifo_write_arbiter #(
    .N(3), .WIDTH(8), .PACKET_MODE(1), .MAX_PACKET(4)
  ) u_dut_b (
    .clk              (clk),
    .rst              (rst),
    .req_valid_in     (b_valid),
    .req_data_in      (b_data),
    .req_last_in      (b_last),
    .req_ready_out    (b_ready),
    .wrreq_out        (b_wr),
    .data_out         (b_dout),
    .full_in          (b_full),
    .almost_full_in   (b_af),
    .grant_idx_out    (b_gidx),
    .locked_out       (b_lock),
    .overflow_err_out (b_ovf),
    .watchdog_err_out (b_wd)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check ready mid-cycle, then check registered outputs after the edge.
  task automatic step(input int which, input logic [2:0] v, input logic [23:0] d,
                      input logic [2:0] l, input logic af, input logic fl,
                      input logic [2:0] e_rdy, input logic e_wr, input logic [7:0] e_dout,
                      input logic [1:0] e_g, input logic e_lock, input string tag);
    logic [2:0] rdy;
    logic       wr, lk;
    logic [7:0] dout;
    logic [1:0] g;
    if (which == 0) begin
      a_valid = v; a_data = d; a_last = l; a_af = af; a_full = fl;
    end else begin
      b_valid = v; b_data = d; b_last = l; b_af = af; b_full = fl;
    end
    #1;
    rdy = (which == 0) ? a_ready : b_ready;
    check_eq({tag, " ready"}, 32'(rdy), 32'(e_rdy));
    @(posedge clk);
    #1;
    wr   = (which == 0) ? a_wr : b_wr;
    dout = (which == 0) ? a_dout : b_dout;
    g    = (which == 0) ? a_gidx : b_gidx;
    lk   = (which == 0) ? a_lock : b_lock;
    check_eq({tag, " wrreq"}, 32'(wr), 32'(e_wr));
    check_eq({tag, " data"}, 32'(dout), 32'(e_dout));
    check_eq({tag, " grant"}, 32'(g), 32'(e_g));
    check_eq({tag, " locked"}, 32'(lk), 32'(e_lock));
  endtask

  localparam logic [23:0] AData = {8'h12, 8'hA5, 8'h10};

  initial begin
    rst = 1'b1;
    a_valid = '0; a_data = '0; a_last = '0; a_af = 1'b0; a_full = 1'b0;
    b_valid = '0; b_data = '0; b_last = '0; b_af = 1'b0; b_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst a wrreq", 32'(a_wr), 32'd0);
    check_eq("rst a data", 32'(a_dout), 32'd0);
    check_eq("rst a grant", 32'(a_gidx), 32'd0);
    check_eq("rst a ready", 32'(a_ready), 32'd0);
    check_eq("rst b locked", 32'(b_lock), 32'd0);
    check_eq("rst b errs", 32'({b_ovf, b_wd, a_ovf, a_wd}), 32'd0);
    rst = 1'b0;

    // Per-beat round robin, all requesters valid.
    for (int k = 0; k < 6; k++) begin
      case (k % 3)
        0: step(0, 3'b111, AData, 3'b000, 0, 0, 3'b001, 1, 8'h10, 2'd0, 0, "rr0");
        1: step(0, 3'b111, AData, 3'b000, 0, 0, 3'b010, 1, 8'hA5, 2'd1, 0, "rr1");
        default: step(0, 3'b111, AData, 3'b000, 0, 0, 3'b100, 1, 8'h12, 2'd2, 0, "rr2");
      endcase
    end

    // Lone requester 1, then the pointer must sit at 2.
    step(0, 3'b010, AData, 3'b000, 0, 0, 3'b010, 1, 8'hA5, 2'd1, 0, "solo1");
    step(0, 3'b111, AData, 3'b000, 0, 0, 3'b100, 1, 8'h12, 2'd2, 0, "ptr2");
    step(0, 3'b000, AData, 3'b000, 0, 0, 3'b000, 0, 8'h12, 2'd2, 0, "idle hold");
    check_eq("a ovf clean", 32'(a_ovf), 32'd0);

    // almost_full stalls issue without disturbing the round-robin order.
    for (int k = 0; k < 5; k++) begin
      step(0, 3'b111, AData, 3'b000, 1, 0, 3'b000, 0, 8'h12, 2'd2, 0, "af stall");
    end
    step(0, 3'b111, AData, 3'b000, 0, 0, 3'b001, 1, 8'h10, 2'd0, 0, "af resume0");
    step(0, 3'b111, AData, 3'b000, 0, 0, 3'b010, 1, 8'hA5, 2'd1, 0, "af resume1");

    // full_in while a write is on the port: no new grant, sticky overflow error.
    step(0, 3'b111, AData, 3'b000, 0, 1, 3'b000, 0, 8'hA5, 2'd1, 0, "full");
    check_eq("a ovf set", 32'(a_ovf), 32'd1);
    step(0, 3'b000, AData, 3'b000, 0, 0, 3'b000, 0, 8'hA5, 2'd1, 0, "after full");
    check_eq("a ovf sticky", 32'(a_ovf), 32'd1);

    // Packet mode: req0 holds the grant across a bubble while req2 waits.
    step(1, 3'b101, {8'h22, 8'h00, 8'h40}, 3'b100, 0, 0, 3'b001, 1, 8'h40, 2'd0, 1, "pk b1");
    step(1, 3'b101, {8'h22, 8'h00, 8'h41}, 3'b100, 0, 0, 3'b001, 1, 8'h41, 2'd0, 1, "pk b2");
    step(1, 3'b100, {8'h22, 8'h00, 8'h41}, 3'b100, 0, 0, 3'b000, 0, 8'h41, 2'd0, 1, "pk gap");
    step(1, 3'b101, {8'h22, 8'h00, 8'h42}, 3'b100, 0, 0, 3'b001, 1, 8'h42, 2'd0, 1, "pk b3");
    step(1, 3'b101, {8'h22, 8'h00, 8'h43}, 3'b101, 0, 0, 3'b001, 1, 8'h43, 2'd0, 0, "pk b4");
    check_eq("pk no wd", 32'(b_wd), 32'd0);
    step(1, 3'b100, {8'h22, 8'h00, 8'h00}, 3'b100, 0, 0, 3'b100, 1, 8'h22, 2'd2, 0, "pk req2");
    step(1, 3'b000, {8'h22, 8'h00, 8'h00}, 3'b100, 0, 0, 3'b000, 0, 8'h22, 2'd2, 0, "pk idle");

    // Watchdog: req1 never sends last; forced unlock after 4 beats, then req2.
    step(1, 3'b110, {8'h22, 8'h50, 8'h00}, 3'b100, 0, 0, 3'b010, 1, 8'h50, 2'd1, 1, "wd b1");
    step(1, 3'b110, {8'h22, 8'h51, 8'h00}, 3'b100, 0, 0, 3'b010, 1, 8'h51, 2'd1, 1, "wd b2");
    step(1, 3'b110, {8'h22, 8'h52, 8'h00}, 3'b100, 0, 0, 3'b010, 1, 8'h52, 2'd1, 1, "wd b3");
    check_eq("wd not yet", 32'(b_wd), 32'd0);
    step(1, 3'b110, {8'h22, 8'h53, 8'h00}, 3'b100, 0, 0, 3'b010, 1, 8'h53, 2'd1, 0, "wd b4");
    check_eq("wd set", 32'(b_wd), 32'd1);
    step(1, 3'b110, {8'h22, 8'h54, 8'h00}, 3'b100, 0, 0, 3'b100, 1, 8'h22, 2'd2, 0, "wd next");

    // Reset mid-packet discards the lock and the pending write.
    step(1, 3'b001, {8'h00, 8'h00, 8'h60}, 3'b000, 0, 0, 3'b001, 1, 8'h60, 2'd0, 1, "rp lock");
    rst = 1'b1;
    step(1, 3'b011, {8'h00, 8'h71, 8'h61}, 3'b010, 0, 0, 3'b000, 0, 8'h00, 2'd0, 0, "rp rst");
    check_eq("rp errs clear", 32'({b_ovf, b_wd}), 32'd0);
    rst = 1'b0;
    step(1, 3'b110, {8'h22, 8'h71, 8'h00}, 3'b010, 0, 0, 3'b010, 1, 8'h71, 2'd1, 0, "rp first");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
